// File: rtl/lfm_burst_sequencer.sv
// Burst controller in front of the LFM chirp DDS. It accepts and validates one
// configuration, then strobes the DDS once per pulse with a programmable idle gap between pulses.
module lfm_burst_sequencer #(
    parameter int unsigned GAP_W   = 32,
    parameter int unsigned PULSE_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [31:0]        cfg_f_start,
    input  logic [31:0]        cfg_f_stop,
    input  logic [31:0]        cfg_f_clk,
    input  logic [63:0]        cfg_chirp_len,
    input  logic [GAP_W-1:0]   cfg_gap,
    input  logic [PULSE_W-1:0] cfg_num_pulses,
    input  logic               abort,
    output logic               dds_start,
    output logic [31:0]        dds_f_start,
    output logic [31:0]        dds_f_stop,
    output logic [31:0]        dds_f_clk,
    output logic [63:0]        dds_chirp_len,
    input  logic               dds_busy,
    input  logic               dds_done,
    output logic               seq_busy,
    output logic [PULSE_W-1:0] pulse_idx,
    output logic               burst_done,
    output logic               burst_aborted,
    output logic               err_cfg,
    output logic [1:0]         err_code,
    output logic               err_nack
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_START, S_RUN, S_GAP, S_DONE
    } state_t;

    state_t             state;
    logic [GAP_W-1:0]   gap_reg;
    logic [GAP_W-1:0]   gap_cnt;
    logic [PULSE_W-1:0] num_reg;
    logic               abort_flag;
    logic               first_run;
    logic [1:0]         cfg_err;
    logic               abort_hit;
    logic               last_pulse;

    assign seq_busy  = (state != S_IDLE);
    assign cfg_ready = !seq_busy;

    // Validation of the latched config; 33-bit compare so 2*f_stop cannot wrap.
    always_comb begin
        cfg_err = 2'd0;
        if (dds_f_clk == 32'd0 || dds_chirp_len == 64'd0) begin
            cfg_err = 2'd1;
        end else if (dds_f_stop < dds_f_start) begin
            cfg_err = 2'd2;
        end else if ({dds_f_stop, 1'b0} > {1'b0, dds_f_clk}) begin
            cfg_err = 2'd3;
        end
    end

    assign abort_hit  = abort_flag | abort;
    assign last_pulse = (num_reg != '0) && (PULSE_W'(pulse_idx + PULSE_W'(1)) == num_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            gap_reg       <= '0;
            gap_cnt       <= '0;
            num_reg       <= '0;
            abort_flag    <= 1'b0;
            first_run     <= 1'b0;
            dds_start     <= 1'b0;
            dds_f_start   <= '0;
            dds_f_stop    <= '0;
            dds_f_clk     <= '0;
            dds_chirp_len <= '0;
            pulse_idx     <= '0;
            burst_done    <= 1'b0;
            burst_aborted <= 1'b0;
            err_cfg       <= 1'b0;
            err_code      <= 2'd0;
            err_nack      <= 1'b0;
        end else begin
            dds_start     <= 1'b0;
            burst_done    <= 1'b0;
            burst_aborted <= 1'b0;
            err_cfg       <= 1'b0;
            err_nack      <= 1'b0;
            first_run     <= (state == S_START);
            case (state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        dds_f_start   <= cfg_f_start;
                        dds_f_stop    <= cfg_f_stop;
                        dds_f_clk     <= cfg_f_clk;
                        dds_chirp_len <= cfg_chirp_len;
                        gap_reg       <= cfg_gap;
                        num_reg       <= cfg_num_pulses;
                        pulse_idx     <= '0;
                        err_code      <= 2'd0;
                        abort_flag    <= 1'b0;
                        state         <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (cfg_err != 2'd0) begin
                        err_code <= cfg_err;
                        err_cfg  <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        dds_start <= 1'b1;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    abort_flag <= abort_hit;
                    state      <= S_RUN;
                end
                S_RUN: begin
                    // Busy low on the first RUN cycle means the DDS ignored the start;
                    // the nack strobe lands together with burst_done.
                    if (first_run && !dds_busy) begin
                        err_nack      <= 1'b1;
                        abort_flag    <= 1'b1;
                        burst_done    <= 1'b1;
                        burst_aborted <= 1'b1;
                        state         <= S_DONE;
                    end else if (dds_done) begin
                        if (abort_hit || last_pulse) begin
                            abort_flag    <= abort_hit;
                            burst_done    <= 1'b1;
                            burst_aborted <= abort_hit;
                            state         <= S_DONE;
                        end else begin
                            pulse_idx <= PULSE_W'(pulse_idx + PULSE_W'(1));
                            if (gap_reg == '0) begin
                                dds_start <= 1'b1;
                                state     <= S_START;
                            end else begin
                                gap_cnt <= gap_reg;
                                state   <= S_GAP;
                            end
                        end
                    end else begin
                        abort_flag <= abort_hit;
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        abort_flag    <= 1'b1;
                        burst_done    <= 1'b1;
                        burst_aborted <= 1'b1;
                        state         <= S_DONE;
                    end else if (gap_cnt == GAP_W'(1)) begin
                        dds_start <= 1'b1;
                        state     <= S_START;
                    end else begin
                        gap_cnt <= GAP_W'(gap_cnt - GAP_W'(1));
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lfm_burst_sequencer.md
# lfm_burst_sequencer

Control stage directly upstream of the LFM chirp DDS. It accepts one burst configuration through a valid/ready handshake and validates it. It then drives the DDS `start`/parameter inputs to emit `num_pulses` identical up-chirps separated by a programmable idle gap, tracking DDS `busy`/`done` and reporting burst completion, abort and errors.

## Interface
- `GAP_W`, 32: width of inter-pulse gap counter.
- `PULSE_W`, 16: width of pulse count and index.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cfg_valid`  in  1  configuration offered.
- `cfg_ready`  out  1  high only in IDLE; transfer on `cfg_valid && cfg_ready`.
- `cfg_f_start`, `cfg_f_stop`, `cfg_f_clk`  in  32 each  chirp start/stop frequency and sample clock, in Hz.
- `cfg_chirp_len`  in  64  samples per chirp.
- `cfg_gap`  in  GAP_W  idle cycles between pulses.
- `cfg_num_pulses`  in  PULSE_W  pulses per burst; 0 = continuous until abort.
- `abort`  in  1  stop the burst after the current pulse.
- `dds_start`  out  1  one-cycle start strobe to the DDS.
- `dds_f_start`, `dds_f_stop`, `dds_f_clk`  out  32 each  registered copies of the accepted config.
- `dds_chirp_len`  out  64  registered copy of the accepted config.
- `dds_busy`, `dds_done`  in  1 each  DDS status.
- `seq_busy`  out  1  high in every state except IDLE.
- `pulse_idx`  out  PULSE_W  0-based index of the current pulse.
- `burst_done`  out  1  one-cycle strobe at burst end.
- `burst_aborted`  out  1  valid with `burst_done`; 1 if ended by abort or error.
- `err_cfg`  out  1  one-cycle strobe on rejected config.
- `err_code`  out  2  held until next accept. 1 = `f_clk==0` or `chirp_len==0`; 2 = `f_stop<f_start`; 3 = `2*f_stop>f_clk` (33-bit compare). Priority 1>2>3.
- `err_nack`  out  1  one-cycle strobe when the DDS did not accept start.

## Operation
- States: IDLE, CHECK, START, RUN, GAP, DONE.
- **IDLE.** On transfer, latch all `cfg_*` fields into the `dds_*` / internal registers. Clear `pulse_idx` and `err_code`. Go to CHECK.
- **CHECK** (1 cycle).
  - If the config is invalid: set `err_code`, pulse `err_cfg`, go to IDLE. No `dds_start` is issued and `burst_done` is not asserted.
  - Else go to START.
- **START.** `dds_start=1` for exactly this cycle. Go to RUN.
- **RUN.**
  - First RUN cycle with `dds_busy==0`: pulse `err_nack`, set abort flag, go to DONE.
  - On `dds_done`:
    - If abort is pending, or `pulse_idx+1==num_pulses` (with `num_pulses≠0`), go to DONE.
    - Otherwise increment `pulse_idx`. If `gap==0`, go to START; else load the gap counter with `gap` and go to GAP.
- **GAP.** Decrement the counter each cycle. When it reaches 1, go to START (exactly `gap` cycles in GAP). `abort` in GAP goes to DONE with `burst_aborted=1`.
- **`abort` during RUN.** Latched as pending. The DDS has no abort input, so the current chirp completes. `abort` during START is also latched. `abort` in IDLE or CHECK is ignored.
- **DONE** (1 cycle). `burst_done=1`, `burst_aborted` = abort flag. Go to IDLE.
- **Continuous mode.** `pulse_idx` wraps modulo 2^PULSE_W.
- **Held outputs.** `dds_*` parameter outputs are stable from accept until the next accept; they are not cleared in IDLE.
- **Reset.** All registered outputs 0, state IDLE, so `cfg_ready=1` and `seq_busy=0`. Reset mid-burst leaves the DDS to finish on its own. After reset the sequencer ignores `dds_done` while in IDLE.

## Timing
- Accept edge at t0 → CHECK in cycle t0+1 → `dds_start` high in cycle t0+2.
- The DDS raises `dds_busy` in cycle t0+3. This is the first RUN cycle, where `dds_busy` is checked.
- `dds_done` seen in cycle d → next `dds_start` in cycle d+1+gap.
- For the last pulse: `dds_done` seen in cycle d → `burst_done` in cycle d+1 → `cfg_ready` in cycle d+2.
- `dds_done` and `abort` in the same cycle: the abort wins; the burst ends with `burst_aborted=1`.
- `seq_busy` is combinational from the state (`state≠IDLE`). `cfg_ready` is `!seq_busy`.

## Test plan
- **Single pulse.** f_start=10, f_stop=100, f_clk=1000, chirp_len=8, pulses=1, gap=0.
  - Exactly one `dds_start`, 2 cycles after accept.
  - `burst_done=1` and `burst_aborted=0` one cycle after `dds_done`.
- **Gap spacing.** pulses=3, gap=5, chirp_len=4.
  - Three `dds_start` strobes, each 6 cycles after the preceding `dds_done`.
  - `pulse_idx` goes 0,1,2.
  - One `burst_done`.
- **Config rejects.**
  - f_clk=0 → `err_code=1`.
  - f_stop=50, f_start=100 → `err_code=2`.
  - f_stop=600, f_clk=1000 → `err_code=3`.
  - Each case: `err_cfg` strobes and no `dds_start` is issued.
- **Abort.** pulses=0, gap=10.
  - Abort mid-RUN of pulse 2: the chirp completes, then `burst_done` with `burst_aborted=1`, and no further start.
  - Abort in GAP: `burst_done` on the next cycle.
- **DDS nack.** Bench DDS model holds `dds_busy=0`.
  - `err_nack` in the first RUN cycle, then `burst_done` with `burst_aborted=1`.
- **Async reset mid-GAP.**
  - All outputs 0 immediately; `cfg_ready=1` after release.
  - A new config is accepted and runs normally.
